// File: rtl/heichips25_pkg.sv
// Shared types and constants for the nibble-serial memory bridge.
package heichips25_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_CMD  = 3'd1,
    TX_STRB = 3'd2,
    TX_ADDR = 3'd3,
    TX_DATA = 3'd4,
    RX      = 3'd5,
    RSP     = 3'd6
  } bridge_state_e;

  localparam logic [3:0] CMD_READ  = 4'h0;
  localparam logic [3:0] CMD_WRITE = 4'h1;
  localparam int         RSP_ERR_BIT = 0;

endpackage

// File: rtl/mem_nibble_bridge_if.sv
// Core-side 32b request/response channel of the nibble bridge.
// valid/ready: a beat transfers on the posedge where both are high; the sender holds its payload stable while valid is high.
interface mem_nibble_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_strb;
  logic            req_write;
  logic            req_valid;
  logic            req_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic            rsp_valid;
  logic            rsp_ready;

  modport master (
    output req_addr, req_wdata, req_strb, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_rdata, rsp_error, rsp_valid
  );

  modport slave (
    input  req_addr, req_wdata, req_strb, req_write, req_valid, rsp_ready,
    output req_ready, rsp_rdata, rsp_error, rsp_valid
  );
endinterface

// File: rtl/mem_nibble_bridge.sv
// Serialises one 32b memory request into a nibble frame on the pins and
// collects the nibble response back into a single response beat.
module mem_nibble_bridge
  import heichips25_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_nibble_bridge_if.slave   mem,
  output logic [3:0]           tx_data,
  output logic                 tx_valid,
  input  logic [3:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 busy,
  output bridge_state_e        state_dbg
);

  localparam int NIB_MAX = ((AW > DW) ? AW : DW) / 4;
  localparam int NIB_W   = (NIB_MAX > 1) ? $clog2(NIB_MAX) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [NIB_W-1:0] ADDR_LAST = NIB_W'(AW/4 - 1);
  localparam logic [NIB_W-1:0] DATA_LAST = NIB_W'(DW/4 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  bridge_state_e    state, state_nxt;
  logic [NIB_W-1:0] nib_idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [AW-1:0]    addr_sh;
  logic [DW-1:0]    data_sh;
  logic [3:0]       strb_q;
  logic             write_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;
  logic             nib_adv;
  logic             timeout;

  assign state_dbg = state;
  assign busy      = (state != IDLE);
  assign timeout   = (state == RX) && !rx_valid && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt     = state;
    mem.req_ready = 1'b0;
    mem.rsp_valid = 1'b0;
    mem.rsp_error = 1'b0;
    mem.rsp_rdata = '0;
    tx_valid      = 1'b0;
    tx_data       = 4'h0;
    nib_adv       = 1'b0;
    case (state)
      IDLE: begin
        mem.req_ready = 1'b1;
        if (mem.req_valid) state_nxt = TX_CMD;
      end
      TX_CMD: begin
        tx_valid  = 1'b1;
        tx_data   = write_q ? CMD_WRITE : CMD_READ;
        state_nxt = TX_STRB;
      end
      TX_STRB: begin
        tx_valid  = 1'b1;
        tx_data   = strb_q;
        state_nxt = TX_ADDR;
      end
      TX_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = addr_sh[3:0];
        nib_adv  = 1'b1;
        if (nib_idx == ADDR_LAST) state_nxt = write_q ? TX_DATA : RX;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_sh[3:0];
        nib_adv  = 1'b1;
        if (nib_idx == DATA_LAST) state_nxt = RX;
      end
      RX: begin
        nib_adv = rx_valid;
        // A write acknowledges with a single status nibble.
        if (rx_valid && (write_q || nib_idx == DATA_LAST)) state_nxt = RSP;
        else if (timeout) state_nxt = RSP;
      end
      RSP: begin
        mem.rsp_valid = 1'b1;
        mem.rsp_error = err_q;
        mem.rsp_rdata = rdata_q;
        if (mem.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      nib_idx <= '0;
      tmo_cnt <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) nib_idx <= '0;
      else if (nib_adv)       nib_idx <= nib_idx + 1'b1;
      // The idle counter only runs while waiting on the pins in RX.
      if (state != RX || rx_valid) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        IDLE: if (mem.req_valid) begin
          addr_sh <= mem.req_addr;
          data_sh <= mem.req_wdata;
          strb_q  <= mem.req_strb[3:0];
          write_q <= mem.req_write;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        TX_ADDR: addr_sh <= addr_sh >> 4;
        TX_DATA: data_sh <= data_sh >> 4;
        RX: begin
          if (rx_valid) begin
            if (write_q) err_q   <= rx_data[RSP_ERR_BIT];
            else         rdata_q <= {rx_data, rdata_q[DW-1:4]};
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_nibble_bridge.sv
// Directed bench for mem_nibble_bridge: frames, responses, timeout, backpressure, reset.
module tb_mem_nibble_bridge;
  import heichips25_pkg::*;

  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    tx_data;
  logic          tx_valid;
  logic [3:0]    rx_data;
  logic          rx_valid;
  logic          busy;
  bridge_state_e state_dbg;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  mem_nibble_bridge_if #(.AW(32), .DW(32)) mem ();

  mem_nibble_bridge #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem.slave),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Presents a request at a negedge and returns at the negedge after acceptance.
  task automatic send_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic write);
    int n = 0;
    mem.req_addr  = addr;
    mem.req_wdata = wdata;
    mem.req_strb  = strb;
    mem.req_write = write;
    mem.req_valid = 1'b1;
    while (!mem.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_accept", 32'(mem.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem.req_valid = 1'b0;
  endtask

  task automatic capture_tx(input string tag);
    int guard = 0;
    got_q.delete();
    while (tx_valid && guard < 40) begin
      got_q.push_back(tx_data);
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_nib%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic feed_rx(input logic [3:0] nib, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = nib;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 4'h0;
  endtask

  task automatic finish_rsp(input string tag, input logic [31:0] rdata, input logic err);
    int n = 0;
    while (!mem.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(mem.rsp_valid), 32'd1);
    check_eq({tag, "_rdata"}, mem.rsp_rdata, rdata);
    check_eq({tag, "_err"}, 32'(mem.rsp_error), 32'(err));
    mem.rsp_ready = 1'b1;
    @(negedge clk);
    mem.rsp_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(mem.rsp_valid), 32'd0);
    check_eq({tag, "_rdy"}, 32'(mem.req_ready), 32'd1);
  endtask

  task automatic load_exp(input logic [71:0] nibs, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(nibs[71 - 4*i -: 4]);
  endtask

  initial begin
    int n;
    logic [3:0] rd_nibs [8];
    rst = 1'b1;
    rx_data = 4'h0;
    rx_valid = 1'b0;
    mem.req_addr = '0;
    mem.req_wdata = '0;
    mem.req_strb = '0;
    mem.req_write = 1'b0;
    mem.req_valid = 1'b0;
    mem.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(mem.req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(mem.rsp_valid), 32'd0);
    check_eq("rst_rsp_error", 32'(mem.rsp_error), 32'd0);
    check_eq("rst_rdata", mem.rsp_rdata, 32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Read 0x0000_1234
    load_exp({4'h0,4'hF,4'h4,4'h3,4'h2,4'h1,4'h0,4'h0,4'h0,4'h0,32'h0}, 10);
    send_req(32'h0000_1234, 32'h0, 4'hF, 1'b0);
    check_eq("rd_busy", 32'(busy), 32'd1);
    capture_tx("rd_tx");
    rd_nibs = '{4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1};
    for (int i = 0; i < 8; i++) feed_rx(rd_nibs[i], 0);
    check_eq("rd_rsp_latency", 32'(mem.rsp_valid), 32'd1);
    finish_rsp("rd", 32'h1234_5678, 1'b0);

    // Write 0x8000_0004 <- 0xCAFE_BABE, strb 0x3
    load_exp({4'h1,4'h3,4'h4,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h8,
              4'hE,4'hB,4'hA,4'hB,4'hE,4'hF,4'hA,4'hC}, 18);
    send_req(32'h8000_0004, 32'hCAFE_BABE, 4'h3, 1'b1);
    capture_tx("wr_tx");
    feed_rx(4'h0, 0);
    check_eq("wr_rsp_latency", 32'(mem.rsp_valid), 32'd1);
    finish_rsp("wr", 32'h0, 1'b0);

    // Write with error status nibble
    send_req(32'h8000_0004, 32'hCAFE_BABE, 4'h3, 1'b1);
    capture_tx("wre_tx");
    feed_rx(4'h1, 0);
    finish_rsp("wre", 32'h0, 1'b1);

    // Read with 3-cycle rx gaps, response 0xDEAD_BEEF
    load_exp({4'h0,4'hF,4'h4,4'h3,4'h2,4'h1,4'h0,4'h0,4'h0,4'h0,32'h0}, 10);
    send_req(32'h0000_1234, 32'h0, 4'hF, 1'b0);
    capture_tx("gap_tx");
    rd_nibs = '{4'hF,4'hE,4'hE,4'hB,4'hD,4'hA,4'hE,4'hD};
    for (int i = 0; i < 8; i++) feed_rx(rd_nibs[i], 3);
    check_eq("gap_rsp_latency", 32'(mem.rsp_valid), 32'd1);
    finish_rsp("gap", 32'hDEAD_BEEF, 1'b0);

    // Read with no response at all
    send_req(32'h0000_1234, 32'h0, 4'hF, 1'b0);
    capture_tx("tmo_tx");
    n = 0;
    while (!mem.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_cycles", 32'(n), 32'(TMO));
    finish_rsp("tmo", 32'h0, 1'b1);

    // Read timing out after 3 of 8 nibbles
    send_req(32'h0000_1234, 32'h0, 4'hF, 1'b0);
    capture_tx("ptmo_tx");
    for (int i = 0; i < 3; i++) feed_rx(4'h9, 0);
    n = 0;
    while (!mem.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ptmo_cycles", 32'(n), 32'(TMO));
    finish_rsp("ptmo", 32'h0, 1'b1);

    // Backpressure: hold rsp_ready low with a new request waiting
    send_req(32'h0000_1234, 32'h0, 4'hF, 1'b0);
    capture_tx("bp_tx");
    rd_nibs = '{4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8};
    for (int i = 0; i < 8; i++) feed_rx(rd_nibs[i], 0);
    mem.req_addr  = 32'h0000_1234;
    mem.req_write = 1'b0;
    mem.req_strb  = 4'hF;
    mem.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_valid%0d", i), 32'(mem.rsp_valid), 32'd1);
      check_eq($sformatf("bp_rdata%0d", i), mem.rsp_rdata, 32'h8765_4321);
      check_eq($sformatf("bp_err%0d", i), 32'(mem.rsp_error), 32'd0);
      check_eq($sformatf("bp_rdy%0d", i), 32'(mem.req_ready), 32'd0);
      @(negedge clk);
    end
    mem.rsp_ready = 1'b1;
    @(negedge clk);
    mem.rsp_ready = 1'b0;
    check_eq("bp_after_valid", 32'(mem.rsp_valid), 32'd0);
    check_eq("bp_after_rdy", 32'(mem.req_ready), 32'd1);
    check_eq("bp_after_notx", 32'(tx_valid), 32'd0);
    @(negedge clk);
    mem.req_valid = 1'b0;
    check_eq("bp_new_cmd_valid", 32'(tx_valid), 32'd1);
    check_eq("bp_new_cmd", 32'(tx_data), 32'(CMD_READ));

    // Reset in the middle of TX_ADDR (nibble 4)
    repeat (6) @(negedge clk);
    check_eq("mid_state", 32'(state_dbg), 32'(TX_ADDR));
    check_eq("mid_nib4", 32'(tx_data), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("mid_req_ready", 32'(mem.req_ready), 32'd1);
    check_eq("mid_busy", 32'(busy), 32'd0);

    // rx_valid pulses while idle must be ignored
    for (int i = 0; i < 3; i++) feed_rx(4'hF, 1);
    repeat (3) @(negedge clk);
    check_eq("idle_rx_rsp", 32'(mem.rsp_valid), 32'd0);
    check_eq("idle_rx_state", 32'(state_dbg), 32'(IDLE));
    check_eq("idle_rx_tx", 32'(tx_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
